// File: rtl/axis_expand_arb_pkg.sv
// axis_expand_arb_pkg -- shared types and width helpers for axis_expand_arb.
//   arb_state_t : arbiter state encoding (IDLE / GRANT)
//   cnt_w()     : CNT_W, slot counter width for a given EXPAND  (clog2(EXPAND))
//   id_w()      : ID_W, port id width for a given NPORTS        (clog2(NPORTS))
package axis_expand_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int cnt_w(input int expand);
    return $clog2(expand);
  endfunction

  function automatic int id_w(input int nports);
    return $clog2(nports);
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// axis_rr_pick -- combinational round-robin picker.
//   req  : request vector, one bit per port
//   last : index of the port granted most recently
//   gnt  : first requesting port at or after (last+1) mod NPORTS, wrapping
//   any  : at least one request present (gnt is 0 otherwise)
module axis_rr_pick #(
  parameter int NPORTS = 4,
  parameter int ID_W   = 2
) (
  input  logic [NPORTS-1:0] req,
  input  logic [ID_W-1:0]   last,
  output logic [ID_W-1:0]   gnt,
  output logic              any
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest requester
  // after 'last' is the one left standing.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = 0;
    for (int i = NPORTS; i >= 1; i--) begin
      idx = (int'(last) + i) % NPORTS;
      if (req[idx]) begin
        gnt = ID_W'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_expand_arb.sv
// axis_expand_arb -- round-robin arbiter that packs EXPAND narrow words from
// one granted port into a single wide output word.
//   clk, rst             : clock, asynchronous active-high reset
//   s_rx_tdata/tvalid    : NPORTS narrow input streams (port p at [p*WIDTH +: WIDTH])
//   s_rx_tready          : per-port ready, only the granted port can be ready
//   m_tx_tdata/tvalid    : packed output, first accepted word in the LSB slot
//   m_tx_tready          : downstream ready
//   m_tx_tid             : source port of the packed word
// Optional (AXIS_EXPAND_ARB_TLAST_EN): s_rx_tlast closes a group early,
// unfilled upper slots read zero, m_tx_tlast flags the short/closing word.
module axis_expand_arb
  import axis_expand_arb_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int EXPAND = 2,
  parameter int NPORTS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NPORTS*WIDTH-1:0]     s_rx_tdata,
  input  logic [NPORTS-1:0]           s_rx_tvalid,
  output logic [NPORTS-1:0]           s_rx_tready,
`ifdef AXIS_EXPAND_ARB_TLAST_EN
  input  logic [NPORTS-1:0]           s_rx_tlast,
  output logic                        m_tx_tlast,
`endif
  output logic [EXPAND*WIDTH-1:0]     m_tx_tdata,
  output logic                        m_tx_tvalid,
  input  logic                        m_tx_tready,
  output logic [$clog2(NPORTS)-1:0]   m_tx_tid
);

  localparam int CW = cnt_w(EXPAND);
  localparam int IW = id_w(NPORTS);

  arb_state_t                        state;
  logic [IW-1:0]                     sel, last_grant, pick;
  logic                              pick_any;
  logic [CW-1:0]                     cnt;
  logic [EXPAND-2:0][WIDTH-1:0]      stage;
  logic [EXPAND-1:0][WIDTH-1:0]      packed_w;
  logic [WIDTH-1:0]                  word;
  logic                              gnt_ok, accept, last_slot, done;

  axis_rr_pick #(.NPORTS(NPORTS), .ID_W(IW)) u_pick (
    .req  (s_rx_tvalid),
    .last (last_grant),
    .gnt  (pick),
    .any  (pick_any)
  );

  // Ready only when the output register is free or draining this cycle.
  assign gnt_ok      = (state == GRANT) && (!m_tx_tvalid || m_tx_tready);
  assign s_rx_tready = gnt_ok ? (NPORTS'(1) << sel) : '0;
  assign word        = s_rx_tdata[sel*WIDTH +: WIDTH];
  assign accept      = gnt_ok && s_rx_tvalid[sel];
  assign last_slot   = (cnt == CW'(EXPAND-1));
`ifdef AXIS_EXPAND_ARB_TLAST_EN
  assign done        = accept && (last_slot || s_rx_tlast[sel]);
`else
  assign done        = accept && last_slot;
`endif

  // Closing word: staged slots below cnt, current word at cnt, zeros above.
  // Stale staging from older groups is masked by the cnt comparison.
  always_comb begin
    packed_w = '0;
    for (int k = 0; k < EXPAND-1; k++) begin
      if (CW'(k) < cnt)       packed_w[k] = stage[k];
      else if (CW'(k) == cnt) packed_w[k] = word;
    end
    packed_w[EXPAND-1] = last_slot ? word : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= '0;
      last_grant  <= IW'(NPORTS-1);
      cnt         <= '0;
      stage       <= '0;
      m_tx_tdata  <= '0;
      m_tx_tvalid <= 1'b0;
      m_tx_tid    <= '0;
`ifdef AXIS_EXPAND_ARB_TLAST_EN
      m_tx_tlast  <= 1'b0;
`endif
    end else begin
      // Completion wins over drain so a back-to-back word stays valid.
      if (done)             m_tx_tvalid <= 1'b1;
      else if (m_tx_tready) m_tx_tvalid <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_any) begin
            sel   <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (done) begin
            m_tx_tdata <= packed_w;
            m_tx_tid   <= sel;
`ifdef AXIS_EXPAND_ARB_TLAST_EN
            m_tx_tlast <= s_rx_tlast[sel];
`endif
            cnt        <= '0;
            last_grant <= sel;
            state      <= IDLE;
          end else if (accept) begin
            stage[cnt] <= word;
            cnt        <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axis_expand_arb.md
AXIS_EXPAND_ARB -- requirements
Module: axis_expand_arb

Interface
REQ-001 Parameter WIDTH, default 8, narrow input word width in bits.
REQ-002 Parameter EXPAND, default 2, narrow words packed per output word; legal range 2..16.
REQ-003 Parameter NPORTS, default 4, number of input requesters; legal range 2..8.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 s_rx_tdata  input  NPORTS*WIDTH  port p occupies bits [p*WIDTH +: WIDTH].
REQ-007 s_rx_tvalid  input  NPORTS  per-port valid.
REQ-008 s_rx_tready  output  NPORTS  per-port ready.
REQ-009 m_tx_tdata  output  EXPAND*WIDTH  packed word; first accepted narrow word in slot 0 (LSBs).
REQ-010 m_tx_tvalid  output  1  packed word valid.
REQ-011 m_tx_tready  input  1  downstream ready.
REQ-012 m_tx_tid  output  clog2(NPORTS)  source port of the packed word.

Function
REQ-013 States: IDLE, GRANT; state held in registers.
REQ-014 IDLE: if any s_rx_tvalid set, the SHALL select the lowest port index at or above (last_grant+1) mod NPORTS holding valid, wrapping; enter GRANT next cycle with sel=that port.
REQ-015 IDLE with no valid: remain IDLE; no grant issued.
REQ-016 s_rx_tready[p] = (state==GRANT) && (sel==p) && (!m_tx_tvalid || m_tx_tready); all other bits 0; combinational from registers and m_tx_tready only.
REQ-017 Accept = s_rx_tvalid[sel] && s_rx_tready[sel]; each accept writes the word into slot cnt of the staging register and increments cnt.
REQ-018 On the accept with cnt==EXPAND-1: staging plus current word loaded into m_tx_tdata, m_tx_tid<=sel, m_tx_tvalid<=1, cnt<=0, last_grant<=sel, state<=IDLE.
REQ-019 Grant held for exactly one full group; words from different ports never share one output word.
REQ-020 Grant is never revoked while sel deasserts valid; block waits in GRANT indefinitely.
REQ-021 m_tx_tvalid clears on m_tx_tready when no new group completes in the same cycle; simultaneous drain and completion keeps m_tx_tvalid=1 with new data.
REQ-022 m_tx_tdata, m_tx_tid stable while m_tx_tvalid && !m_tx_tready.
REQ-023 Latency: request in IDLE at cycle t -> first accept at t+1 earliest; output valid the cycle after the EXPAND-th accept; one IDLE bubble between groups; peak throughput EXPAND/(EXPAND+1) narrow words per cycle.

Reset
REQ-024 Reset: state=IDLE, cnt=0, last_grant=NPORTS-1 (port 0 wins first), m_tx_tvalid=0, m_tx_tid=0, m_tx_tdata=0, s_rx_tready=0.
REQ-025 Reset mid-group discards partial staging; mid-output discards the pending packed word.

Configuration
REQ-026 Macro AXIS_EXPAND_ARB_TLAST_EN defined: ports s_rx_tlast (input, NPORTS) and m_tx_tlast (output, 1) exist; accept with s_rx_tlast[sel]=1 closes the group early, unfilled upper slots zero, m_tx_tlast=1, return IDLE.
REQ-027 Macro not defined: no tlast ports; groups always EXPAND words.
REQ-028 With macro, tlast on slot EXPAND-1 behaves as full group with m_tx_tlast=1; m_tx_tlast resets to 0.

Structure
REQ-029 Package axis_expand_arb_pkg holds state encoding (IDLE/GRANT) and width constants CNT_W=clog2(EXPAND), ID_W=clog2(NPORTS).
REQ-030 Sub-module axis_rr_pick: combinational round-robin picker (request vector, last_grant -> grant index, any).

Verification (WIDTH=8, EXPAND=2, NPORTS=3)
REQ-031 Port0 sends 0x11,0x22, ready=1 -> m_tx_tdata=0x2211, tid=0, one cycle after second accept.
REQ-032 All ports valid continuously (p0 0xA0.., p1 0xB0.., p2 0xC0..) -> tid sequence 0,1,2,0; no mixed bytes.
REQ-033 m_tx_tready=0 with word pending, port1 valid -> s_rx_tready all 0, output stable; release -> drain then continue.
REQ-034 Port2 sends 0x55 then deasserts valid 5 cycles -> grant held, no output until 0x66 arrives -> 0x6655, tid=2.
REQ-035 Reset asserted after one accepted byte -> all outputs to reset values immediately; next group starts at slot 0, port 0 first.
REQ-036 TLAST_EN: port1 sends 0x77 with tlast -> m_tx_tdata=0x0077, m_tx_tlast=1, tid=1.
